add_arbiter: RTL and testbench

Round-robin arbiter and two-stage sequencer that shares one 32-bit carry-lookahead adder instance (`ADD`) among up to NUM_REQ requesters (PC increment, branch target, ALU, load/store address). The block picks one requester per cycle, registers its operands onto the adder inputs, registers the adder sum/carry into a result stage, and returns the result tagged with the requester index. Result backpressure is supported through a valid/ready handshake.

---
 rtl/add_arbiter.sv | 135 +++++++++++++
 tb/tb_add_arbiter.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/add_arbiter.sv
// rtl/add_arbiter.sv - round-robin arbiter and two-stage sequencer sharing one 32-bit adder
module add_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [NUM_REQ-1:0]     req_i,
    input  logic [NUM_REQ*32-1:0]  op_a_i,
    input  logic [NUM_REQ*32-1:0]  op_b_i,
    output logic [NUM_REQ-1:0]     grant_o,
    output logic [31:0]            add_in1_o,
    output logic [31:0]            add_in2_o,
    input  logic [31:0]            add_sum_i,
    input  logic                   add_carry_i,
    output logic                   res_valid_o,
    input  logic                   res_ready_i,
    output logic [31:0]            res_sum_o,
    output logic                   res_carry_o,
    output logic [IDW-1:0]         res_id_o,
    output logic [31:0]            issue_count_o
);

    logic [NUM_REQ-1:0] grant_q, grant_d, eligible;
    logic [31:0]        add_in1_q, add_in1_d, add_in2_q, add_in2_d;
    logic [31:0]        res_sum_q, res_sum_d, issue_count_q, issue_count_d;
    logic               s1_valid_q, s1_valid_d, res_valid_q, res_valid_d;
    logic               res_carry_q, res_carry_d;
    logic [IDW-1:0]     s1_id_q, s1_id_d, res_id_q, res_id_d, ptr_q, ptr_d;
    logic               advance1, advance2, found;
    logic [IDW-1:0]     win, idx;
    logic [31:0]        win_a, win_b;

    assign advance2 = !res_valid_q || res_ready_i;
    assign advance1 = !s1_valid_q || advance2;
    // The requester granted this cycle is masked so a late-dropped req cannot issue twice.
    assign eligible = req_i & ~grant_q;

    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = IDW'((int'(ptr_q) + k) % NUM_REQ);
            if (!found && eligible[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_comb begin
        win_a = '0;
        win_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (IDW'(i) == win) begin
                win_a = op_a_i[i*32 +: 32];
                win_b = op_b_i[i*32 +: 32];
            end
        end
    end

    always_comb begin
        grant_d       = '0;
        add_in1_d     = add_in1_q;
        add_in2_d     = add_in2_q;
        s1_valid_d    = s1_valid_q;
        s1_id_d       = s1_id_q;
        ptr_d         = ptr_q;
        issue_count_d = issue_count_q;
        res_valid_d   = res_valid_q;
        res_sum_d     = res_sum_q;
        res_carry_d   = res_carry_q;
        res_id_d      = res_id_q;
        if (advance1) begin
            if (found) begin
                add_in1_d     = win_a;
                add_in2_d     = win_b;
                s1_valid_d    = 1'b1;
                s1_id_d       = win;
                grant_d       = {{(NUM_REQ-1){1'b0}}, 1'b1} << win;
                ptr_d         = win;
                issue_count_d = issue_count_q + 32'd1;
            end else begin
                s1_valid_d = 1'b0;
            end
        end
        if (advance2) begin
            res_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                res_sum_d   = add_sum_i;
                res_carry_d = add_carry_i;
                res_id_d    = s1_id_q;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            grant_q       <= '0;
            add_in1_q     <= '0;
            add_in2_q     <= '0;
            s1_valid_q    <= 1'b0;
            s1_id_q       <= '0;
            ptr_q         <= IDW'(NUM_REQ - 1);
            issue_count_q <= '0;
            res_valid_q   <= 1'b0;
            res_sum_q     <= '0;
            res_carry_q   <= 1'b0;
            res_id_q      <= '0;
        end else begin
            grant_q       <= grant_d;
            add_in1_q     <= add_in1_d;
            add_in2_q     <= add_in2_d;
            s1_valid_q    <= s1_valid_d;
            s1_id_q       <= s1_id_d;
            ptr_q         <= ptr_d;
            issue_count_q <= issue_count_d;
            res_valid_q   <= res_valid_d;
            res_sum_q     <= res_sum_d;
            res_carry_q   <= res_carry_d;
            res_id_q      <= res_id_d;
        end
    end

    assign grant_o       = grant_q;
    assign add_in1_o     = add_in1_q;
    assign add_in2_o     = add_in2_q;
    assign res_valid_o   = res_valid_q;
    assign res_sum_o     = res_sum_q;
    assign res_carry_o   = res_carry_q;
    assign res_id_o      = res_id_q;
    assign issue_count_o = issue_count_q;

endmodule

// File: tb/tb_add_arbiter.sv
// tb/tb_add_arbiter.sv - directed table-driven bench for add_arbiter
module tb_add_arbiter;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic [3:0]   req_i;
    logic [127:0] op_a_i, op_b_i;
    logic [3:0]   grant_o;
    logic [31:0]  add_in1_o, add_in2_o, add_sum_i;
    logic         add_carry_i;
    logic         res_valid_o, res_ready_i, res_carry_o;
    logic [31:0]  res_sum_o, issue_count_o;
    logic [1:0]   res_id_o;
    logic [32:0]  full_sum;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk_i = ~clk_i;

    // Behavioural stand-in for the shared adder
    assign full_sum    = {1'b0, add_in1_o} + {1'b0, add_in2_o};
    assign add_sum_i   = full_sum[31:0];
    assign add_carry_i = full_sum[32];

    add_arbiter #(.NUM_REQ(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .op_a_i(op_a_i), .op_b_i(op_b_i),
        .grant_o(grant_o), .add_in1_o(add_in1_o), .add_in2_o(add_in2_o),
        .add_sum_i(add_sum_i), .add_carry_i(add_carry_i), .res_valid_o(res_valid_o),
        .res_ready_i(res_ready_i), .res_sum_o(res_sum_o), .res_carry_o(res_carry_o),
        .res_id_o(res_id_o), .issue_count_o(issue_count_o)
    );

    typedef struct {
        logic [3:0]   req;
        logic [127:0] a;
        logic [127:0] b;
        logic [3:0]   grant;
        logic         rv;
        logic [31:0]  sum;
        logic         carry;
        logic [1:0]   id;
        logic [31:0]  cnt;
    } vec_t;

    vec_t vt[11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    localparam logic [127:0] RR_A = {32'h103, 32'h102, 32'h101, 32'h100};
    localparam logic [127:0] RR_B = {32'h4000, 32'h3000, 32'h2000, 32'h1000};
    localparam logic [127:0] C_A  = {32'h0, 32'hFFFF_FFFF, 64'h0};
    localparam logic [127:0] C_B  = {32'h0, 32'h1, 64'h0};

    logic [3:0] h_req[7]   = '{4'b1010, 4'b1010, 4'b1010, 4'b1010, 4'b0010, 4'b0010, 4'b0000};
    logic [3:0] h_grant[7] = '{4'b1000, 4'b0010, 4'b1000, 4'b0010, 4'b0000, 4'b0010, 4'b0000};
    logic       h_rv[7]    = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [1:0] h_id[7]    = '{2'd0, 2'd3, 2'd1, 2'd3, 2'd1, 2'd0, 2'd1};
    logic [31:0] h_sum[7]  = '{32'd0, 32'd7, 32'd3, 32'd7, 32'd3, 32'd0, 32'd3};

    initial begin
        vt[0]  = '{4'b0001, 128'h5, 128'h3, 4'b0001, 1'b0, 32'h0,    1'b0, 2'd0, 32'd1};
        vt[1]  = '{4'b0000, 128'h5, 128'h3, 4'b0000, 1'b1, 32'h8,    1'b0, 2'd0, 32'd1};
        vt[2]  = '{4'b0100, C_A,    C_B,    4'b0100, 1'b0, 32'h8,    1'b0, 2'd0, 32'd2};
        vt[3]  = '{4'b0000, C_A,    C_B,    4'b0000, 1'b1, 32'h0,    1'b1, 2'd2, 32'd2};
        vt[4]  = '{4'b1111, RR_A,   RR_B,   4'b1000, 1'b0, 32'h0,    1'b1, 2'd2, 32'd3};
        vt[5]  = '{4'b1111, RR_A,   RR_B,   4'b0001, 1'b1, 32'h4103, 1'b0, 2'd3, 32'd4};
        vt[6]  = '{4'b1111, RR_A,   RR_B,   4'b0010, 1'b1, 32'h1100, 1'b0, 2'd0, 32'd5};
        vt[7]  = '{4'b1111, RR_A,   RR_B,   4'b0100, 1'b1, 32'h2101, 1'b0, 2'd1, 32'd6};
        vt[8]  = '{4'b1111, RR_A,   RR_B,   4'b1000, 1'b1, 32'h3102, 1'b0, 2'd2, 32'd7};
        vt[9]  = '{4'b0000, RR_A,   RR_B,   4'b0000, 1'b1, 32'h4103, 1'b0, 2'd3, 32'd7};
        vt[10] = '{4'b0000, RR_A,   RR_B,   4'b0000, 1'b0, 32'h4103, 1'b0, 2'd3, 32'd7};

        rst_i = 1'b1; req_i = '0; op_a_i = '0; op_b_i = '0; res_ready_i = 1'b1;
        step(); step();
        rst_i = 1'b0;
        chk("reset grant", grant_o, 0);
        chk("reset res_valid", res_valid_o, 0);
        chk("reset add_in1", add_in1_o, 0);
        chk("reset res_sum", res_sum_o, 0);
        chk("reset issue_count", issue_count_o, 0);

        for (int i = 0; i < 11; i++) begin
            req_i = vt[i].req; op_a_i = vt[i].a; op_b_i = vt[i].b;
            step();
            chk($sformatf("row%0d grant", i), grant_o, vt[i].grant);
            chk($sformatf("row%0d res_valid", i), res_valid_o, vt[i].rv);
            chk($sformatf("row%0d res_sum", i), res_sum_o, vt[i].sum);
            chk($sformatf("row%0d res_carry", i), res_carry_o, vt[i].carry);
            chk($sformatf("row%0d res_id", i), res_id_o, vt[i].id);
            chk($sformatf("row%0d issue_count", i), issue_count_o, vt[i].cnt);
        end

        // Backpressure: ids 0 and 1 back to back, then three stalled cycles
        op_a_i = {64'h0, 32'h8000_0000, 32'h7};
        op_b_i = {64'h0, 32'h8000_0000, 32'h9};
        req_i = 4'b0011;
        step();
        chk("bp grant0", grant_o, 4'b0001);
        req_i = 4'b0010;
        step();
        chk("bp grant1", grant_o, 4'b0010);
        chk("bp first id", res_id_o, 0);
        res_ready_i = 1'b0; req_i = 4'b0100;
        for (int s = 0; s < 3; s++) begin
            step();
            chk($sformatf("stall%0d grant", s), grant_o, 0);
            chk($sformatf("stall%0d res_valid", s), res_valid_o, 1);
            chk($sformatf("stall%0d res_id", s), res_id_o, 0);
            chk($sformatf("stall%0d res_sum", s), res_sum_o, 32'h10);
            chk($sformatf("stall%0d issue_count", s), issue_count_o, 9);
            chk($sformatf("stall%0d s1 operand", s), add_in1_o, 32'h8000_0000);
        end
        res_ready_i = 1'b1; req_i = 4'b0000;
        step();
        chk("release res_valid", res_valid_o, 1);
        chk("release res_id", res_id_o, 1);
        chk("release res_sum", res_sum_o, 0);
        chk("release res_carry", res_carry_o, 1);
        step();
        chk("drain res_valid", res_valid_o, 0);

        // Held requests: 1 and 3 alternate, then 1 alone is masked for one cycle
        op_a_i = {32'd3, 32'd0, 32'd1, 32'd0};
        op_b_i = {32'd4, 32'd0, 32'd2, 32'd0};
        for (int h = 0; h < 7; h++) begin
            req_i = h_req[h];
            step();
            chk($sformatf("held%0d grant", h), grant_o, h_grant[h]);
            chk($sformatf("held%0d res_valid", h), res_valid_o, h_rv[h]);
            if (h_rv[h]) begin
                chk($sformatf("held%0d res_id", h), res_id_o, h_id[h]);
                chk($sformatf("held%0d res_sum", h), res_sum_o, h_sum[h]);
            end
        end

        // Reset while both stages are full
        op_a_i = {32'd13, 32'd12, 32'd11, 32'd10};
        op_b_i = {32'd1, 32'd1, 32'd1, 32'd1};
        req_i = 4'b1111;
        step(); step();
        chk("pre-reset res_valid", res_valid_o, 1);
        #2 rst_i = 1'b1;
        #1;
        chk("midrst grant", grant_o, 0);
        chk("midrst res_valid", res_valid_o, 0);
        chk("midrst res_id", res_id_o, 0);
        chk("midrst res_sum", res_sum_o, 0);
        chk("midrst add_in2", add_in2_o, 0);
        chk("midrst issue_count", issue_count_o, 0);
        step();
        rst_i = 1'b0; req_i = 4'b0000;
        step();
        chk("postrst res_valid", res_valid_o, 0);
        chk("postrst grant", grant_o, 0);
        op_a_i = {32'd0, 32'd0, 32'd0, 32'h20};
        op_b_i = {32'd0, 32'd0, 32'd0, 32'h22};
        req_i = 4'b1111;
        step();
        chk("postrst first grant", grant_o, 4'b0001);
        chk("postrst issue_count", issue_count_o, 1);
        req_i = 4'b0000;
        step();
        chk("postrst res_valid", res_valid_o, 1);
        chk("postrst res_id", res_id_o, 0);
        chk("postrst res_sum", res_sum_o, 32'h42);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
